rx_frame_checker: RTL and testbench

Parametrised frame-integrity checker for the UART receive path: performs 3-sample majority voting on the oversampled RX line and checks start, parity and stop bits in one block. It extends single-purpose start-glitch detection with configurable data width, even/odd parity, stop-bit checking, sticky status and saturating per-error counters. It sits between the RX edge/bit counters and the RX FSM; the FSM drives the check enables and consumes the one-cycle error pulses.

---
 rtl/rx_frame_checker.sv | 141 ++++++++++++++
 tb/tb_rx_frame_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_checker.sv
// UART receive frame-integrity checker.
// Takes three mid-bit samples of the oversampled RX line, majority-votes them,
// and checks start, parity and stop bits at the last oversample edge of each
// bit. Errors are reported as one-cycle pulses, sticky flags and saturating
// per-error counters.
module rx_frame_checker #(
   parameter int PRESCALE_BITS = 6,
   parameter int DATA_WIDTH    = 8,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     rx_in,
   input  logic [PRESCALE_BITS-1:0] edge_cnt,
   input  logic [PRESCALE_BITS-1:0] Prescale,
   input  logic                     strt_chk_en,
   input  logic                     par_chk_en,
   input  logic                     stp_chk_en,
   input  logic                     par_typ,
   input  logic [DATA_WIDTH-1:0]    p_data,
   input  logic                     err_clr,
   output logic                     sampled_bit,
   output logic                     strt_glitch,
   output logic                     par_err,
   output logic                     stp_err,
   output logic [2:0]               err_sticky,
   output logic [CNT_WIDTH-1:0]     strt_err_cnt,
   output logic [CNT_WIDTH-1:0]     par_err_cnt,
   output logic [CNT_WIDTH-1:0]     stp_err_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [PRESCALE_BITS-1:0] mid, mid_m1, mid_p1, mid_p2, chk_pt;

   logic s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic sampled_bit_q, sampled_bit_d;
   logic strt_glitch_q, strt_glitch_d;
   logic par_err_q, par_err_d;
   logic stp_err_q, stp_err_d;
   logic [2:0] err_sticky_q, err_sticky_d;
   logic [CNT_WIDTH-1:0] strt_cnt_q, strt_cnt_d;
   logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
   logic [CNT_WIDTH-1:0] stp_cnt_q, stp_cnt_d;

   logic       chk_hit;
   logic       exp_par;
   logic [2:0] new_err;

   // Clear takes effect first so an error landing on the clear edge survives.
   function automatic logic [CNT_WIDTH-1:0] cnt_next(
      input logic [CNT_WIDTH-1:0] cur,
      input logic                 hit,
      input logic                 clr
   );
      logic [CNT_WIDTH-1:0] base;
      base = clr ? '0 : cur;
      if (hit && (base != CNT_MAX)) cnt_next = base + 1'b1;
      else                          cnt_next = base;
   endfunction

   // Sample window positions derived from the oversampling ratio.
   always_comb begin
      mid    = Prescale >> 1;
      mid_m1 = mid - PRESCALE_BITS'(1);
      mid_p1 = mid + PRESCALE_BITS'(1);
      mid_p2 = mid + PRESCALE_BITS'(2);
      chk_pt = Prescale - PRESCALE_BITS'(1);
   end

   // Capture the three mid-bit samples and vote once the window has closed.
   always_comb begin
      s0_d          = s0_q;
      s1_d          = s1_q;
      s2_d          = s2_q;
      sampled_bit_d = sampled_bit_q;
      if (edge_cnt == mid_m1) s0_d = rx_in;
      if (edge_cnt == mid)    s1_d = rx_in;
      if (edge_cnt == mid_p1) s2_d = rx_in;
      if (edge_cnt == mid_p2)
         sampled_bit_d = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
   end

   // Evaluate enabled checks at the last oversample edge and update status.
   always_comb begin
      chk_hit = (edge_cnt == chk_pt);
      exp_par = (^p_data) ^ par_typ;
      new_err = 3'b000;
      if (chk_hit) begin
         new_err[0] = strt_chk_en & sampled_bit_q;
         new_err[1] = par_chk_en & (sampled_bit_q != exp_par);
         new_err[2] = stp_chk_en & ~sampled_bit_q;
      end
      strt_glitch_d = new_err[0];
      par_err_d     = new_err[1];
      stp_err_d     = new_err[2];
      err_sticky_d  = (err_clr ? 3'b000 : err_sticky_q) | new_err;
      strt_cnt_d    = cnt_next(strt_cnt_q, new_err[0], err_clr);
      par_cnt_d     = cnt_next(par_cnt_q,  new_err[1], err_clr);
      stp_cnt_d     = cnt_next(stp_cnt_q,  new_err[2], err_clr);
   end

   // State registers; idle line level is 1 so samples reset high.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s0_q          <= 1'b1;
         s1_q          <= 1'b1;
         s2_q          <= 1'b1;
         sampled_bit_q <= 1'b1;
         strt_glitch_q <= 1'b0;
         par_err_q     <= 1'b0;
         stp_err_q     <= 1'b0;
         err_sticky_q  <= 3'b000;
         strt_cnt_q    <= '0;
         par_cnt_q     <= '0;
         stp_cnt_q     <= '0;
      end else begin
         s0_q          <= s0_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         sampled_bit_q <= sampled_bit_d;
         strt_glitch_q <= strt_glitch_d;
         par_err_q     <= par_err_d;
         stp_err_q     <= stp_err_d;
         err_sticky_q  <= err_sticky_d;
         strt_cnt_q    <= strt_cnt_d;
         par_cnt_q     <= par_cnt_d;
         stp_cnt_q     <= stp_cnt_d;
      end
   end

   assign sampled_bit  = sampled_bit_q;
   assign strt_glitch  = strt_glitch_q;
   assign par_err      = par_err_q;
   assign stp_err      = stp_err_q;
   assign err_sticky   = err_sticky_q;
   assign strt_err_cnt = strt_cnt_q;
   assign par_err_cnt  = par_cnt_q;
   assign stp_err_cnt  = stp_cnt_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Bench for rx_frame_checker: table of single-bit vectors plus sequences for
// counter saturation, clear/error collision and mid-bit reset.
module tb_rx_frame_checker;

   logic        CLK = 1'b0;
   logic        RST;
   logic        rx_in;
   logic [5:0]  edge_cnt;
   logic [5:0]  Prescale;
   logic        strt_chk_en, par_chk_en, stp_chk_en, par_typ, err_clr;
   logic [7:0]  p_data;
   logic        sampled_bit, strt_glitch, par_err, stp_err;
   logic [2:0]  err_sticky;
   logic [7:0]  strt_err_cnt, par_err_cnt, stp_err_cnt;

   rx_frame_checker #(.PRESCALE_BITS(6), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .rx_in(rx_in), .edge_cnt(edge_cnt), .Prescale(Prescale),
      .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
      .par_typ(par_typ), .p_data(p_data), .err_clr(err_clr),
      .sampled_bit(sampled_bit), .strt_glitch(strt_glitch), .par_err(par_err),
      .stp_err(stp_err), .err_sticky(err_sticky), .strt_err_cnt(strt_err_cnt),
      .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
   );

   always #5 CLK = ~CLK;

   // zmask bit e set = rx_in low on edge e; en/exp_err are {stp, par, strt}
   typedef struct {
      int          presc;
      logic [63:0] zmask;
      logic [2:0]  en;
      logic        typ;
      logic [7:0]  data;
      logic        drop;
      logic        clr;
      logic        exp_sb;
      logic [2:0]  exp_err;
   } vec_t;

   typedef struct {
      logic       sb;
      logic [2:0] err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int         m_cnt[3];
   logic [2:0] m_sticky;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: pop an expectation on each check edge, track sticky/counters.
   always @(posedge CLK) begin
      logic       chk, clr, rstv;
      logic [2:0] new_err;
      exp_t       e;
      chk  = (edge_cnt == Prescale - 6'd1);
      clr  = err_clr;
      rstv = RST;
      #1;
      new_err = 3'b000;
      if (!rstv) begin
         m_sticky = 3'b000;
         for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      end else begin
         if (chk) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sampled_bit_at_check", {31'd0, sampled_bit}, {31'd0, e.sb});
               new_err = e.err;
            end
         end
         m_sticky = (clr ? 3'b000 : m_sticky) | new_err;
         for (int k = 0; k < 3; k++) begin
            if (clr) m_cnt[k] = 0;
            if (new_err[k] && m_cnt[k] != 255) m_cnt[k]++;
         end
      end
      check("pulses", {29'd0, stp_err, par_err, strt_glitch}, {29'd0, new_err});
      check("err_sticky", {29'd0, err_sticky}, {29'd0, m_sticky});
      check("strt_err_cnt", {24'd0, strt_err_cnt}, m_cnt[0]);
      check("par_err_cnt", {24'd0, par_err_cnt}, m_cnt[1]);
      check("stp_err_cnt", {24'd0, stp_err_cnt}, m_cnt[2]);
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         edge_cnt = 6'd0; rx_in = 1'b1; err_clr = 1'b0;
         strt_chk_en = 1'b0; par_chk_en = 1'b0; stp_chk_en = 1'b0;
      end
   endtask

   task automatic run_bit(input vec_t v);
      exp_t e;
      int   mid;
      mid = v.presc / 2;
      for (int ed = 0; ed < v.presc; ed++) begin
         @(negedge CLK);
         Prescale = 6'(v.presc);
         edge_cnt = 6'(ed);
         rx_in    = ~v.zmask[ed];
         par_typ  = v.typ;
         p_data   = v.data;
         {stp_chk_en, par_chk_en, strt_chk_en} =
            (ed == v.presc - 1 && v.drop) ? 3'b000 : v.en;
         err_clr  = (ed == v.presc - 1) ? v.clr : 1'b0;
         if (ed == v.presc - 1) begin
            e.sb  = v.exp_sb;
            e.err = v.exp_err;
            exp_q.push_back(e);
         end
         if (ed == mid + 2) begin
            @(posedge CLK);
            #1;
            check("sampled_bit_latency", {31'd0, sampled_bit}, {31'd0, v.exp_sb});
         end
      end
   endtask

   vec_t vecs[14];
   vec_t vg;

   initial begin
      //         presc zmask                  en     typ  data   drop clr  sb   err
      vecs[0]  = '{8,  64'h38,                3'b001, 0, 8'h00, 0, 0, 0, 3'b000};
      vecs[1]  = '{8,  64'h10,                3'b001, 0, 8'h00, 0, 0, 1, 3'b001};
      vecs[2]  = '{8,  64'h00,                3'b010, 0, 8'hA5, 0, 0, 1, 3'b010};
      vecs[3]  = '{8,  64'h00,                3'b010, 1, 8'hA5, 0, 0, 1, 3'b000};
      vecs[4]  = '{16, 64'hFFFF,              3'b100, 0, 8'h00, 0, 0, 0, 3'b100};
      vecs[5]  = '{16, 64'h0,                 3'b100, 0, 8'h00, 0, 0, 1, 3'b000};
      vecs[6]  = '{8,  64'hFF,                3'b010, 0, 8'h01, 0, 0, 0, 3'b010};
      vecs[7]  = '{8,  64'h00,                3'b111, 1, 8'h00, 0, 0, 1, 3'b001};
      vecs[8]  = '{8,  64'h28,                3'b100, 0, 8'h00, 0, 0, 0, 3'b100};
      vecs[9]  = '{8,  64'h44,                3'b001, 0, 8'h00, 0, 0, 1, 3'b001};
      vecs[10] = '{62, 64'h0000_0000_C000_0000, 3'b100, 0, 8'h00, 0, 0, 0, 3'b100};
      vecs[11] = '{8,  64'h10,                3'b001, 0, 8'h00, 1, 0, 1, 3'b000};
      vecs[12] = '{8,  64'h18,                3'b010, 1, 8'h03, 0, 0, 0, 3'b010};
      vecs[13] = '{62, 64'h0000_0002_2000_0000, 3'b001, 0, 8'h00, 0, 0, 1, 3'b001};

      RST = 1'b0; rx_in = 1'b1; edge_cnt = 6'd0; Prescale = 6'd8;
      strt_chk_en = 1'b0; par_chk_en = 1'b0; stp_chk_en = 1'b0;
      par_typ = 1'b0; p_data = 8'h00; err_clr = 1'b0;
      m_sticky = 3'b000;
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;

      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      check("reset_sampled_bit", {31'd0, sampled_bit}, 32'd1);
      check("reset_sticky", {29'd0, err_sticky}, 32'd0);
      check("reset_strt_cnt", {24'd0, strt_err_cnt}, 32'd0);

      for (int i = 0; i < 14; i++) run_bit(vecs[i]);
      idle(2);

      // Saturate the start-glitch counter, then collide a glitch with clear.
      vg = vecs[1];
      for (int i = 0; i < 300; i++) run_bit(vg);
      @(posedge CLK); #1;
      check("strt_cnt_saturated", {24'd0, strt_err_cnt}, 32'd255);
      vg.clr = 1'b1;
      run_bit(vg);
      @(posedge CLK); #1;
      check("clr_collide_cnt", {24'd0, strt_err_cnt}, 32'd1);
      check("clr_collide_sticky", {29'd0, err_sticky}, 32'd1);
      idle(1);

      // Clear, build five parity errors, then reset in the middle of a parity bit.
      @(negedge CLK); err_clr = 1'b1;
      idle(1);
      for (int i = 0; i < 5; i++) run_bit(vecs[2]);
      @(posedge CLK); #1;
      check("par_cnt_five", {24'd0, par_err_cnt}, 32'd5);
      for (int ed = 0; ed < 4; ed++) begin
         @(negedge CLK);
         edge_cnt = 6'(ed); rx_in = 1'b0; err_clr = 1'b0;
         par_chk_en = 1'b1; par_typ = 1'b0; p_data = 8'hA5;
      end
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("abort_sampled_bit", {31'd0, sampled_bit}, 32'd1);
      check("abort_par_cnt", {24'd0, par_err_cnt}, 32'd0);
      check("abort_sticky", {29'd0, err_sticky}, 32'd0);
      check("abort_pulses", {29'd0, stp_err, par_err, strt_glitch}, 32'd0);
      for (int ed = 4; ed < 8; ed++) begin
         @(negedge CLK);
         edge_cnt = 6'(ed);
      end
      @(negedge CLK);
      RST = 1'b1; edge_cnt = 6'd0; par_chk_en = 1'b0; rx_in = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("post_abort_par_err", {31'd0, par_err}, 32'd0);
      check("post_abort_par_cnt", {24'd0, par_err_cnt}, 32'd0);
      check("post_abort_sampled", {31'd0, sampled_bit}, 32'd1);

      idle(2);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
